// File: rtl/crc_pkg.sv
// Shared types and CRC helper functions for the parallel CRC block.
// The functions work on maximum-width containers so that one definition
// serves every elaboration of the block; callers pass the real widths.
package crc_pkg;

  localparam int MAX_POLY_WIDTH = 64;
  localparam int MAX_DATA_WIDTH = 512;

  typedef logic [MAX_POLY_WIDTH-1:0] crc_word_t;
  typedef logic [MAX_DATA_WIDTH-1:0] data_word_t;

  // Bit-reverse every complete byte inside the low 'width' bits.
  function automatic data_word_t reflect_bytes(input data_word_t data, input int width);
    data_word_t r;
    r = data;
    for (int b = 0; b < MAX_DATA_WIDTH / 8; b++) begin
      if ((b * 8 + 8) <= width) begin
        for (int j = 0; j < 8; j++) begin
          r[b*8+j] = data[b*8+7-j];
        end
      end
    end
    return r;
  endfunction

  // Bit-reverse the low 'width' bits; bits above 'width' come back as zero.
  function automatic crc_word_t reflect_bits(input crc_word_t value, input int width);
    crc_word_t r;
    r = '0;
    for (int i = 0; i < MAX_POLY_WIDTH; i++) begin
      if (i < width) begin
        r[i] = value[width-1-i];
      end
    end
    return r;
  endfunction

  // Unrolled MSB-first CRC over the low 'data_width' bits of data,
  // starting from init; every step is truncated to poly_width bits.
  function automatic crc_word_t crc_word(input data_word_t data, input int data_width,
                                         input crc_word_t poly, input crc_word_t init,
                                         input int poly_width);
    crc_word_t mask;
    crc_word_t c;
    logic      fb;
    if (poly_width >= MAX_POLY_WIDTH) begin
      mask = '1;
    end else begin
      mask = (crc_word_t'(1) << poly_width) - crc_word_t'(1);
    end
    c = init & mask;
    for (int i = MAX_DATA_WIDTH - 1; i >= 0; i--) begin
      if (i < data_width) begin
        fb = c[poly_width-1] ^ data[i];
        c  = (c << 1) & mask;
        if (fb) begin
          c = c ^ (poly & mask);
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_comb_core.sv
// Purely combinational CRC of one word: input byte reflection, the
// unrolled XOR network, output reflection and the final XOR.
module crc_comb_core
  import crc_pkg::*;
#(
  parameter int unsigned            POLY_WIDTH = 32,
  parameter logic [POLY_WIDTH-1:0]  POLY       = 32'h04C11DB7,
  parameter logic [POLY_WIDTH-1:0]  INIT       = 32'hFFFFFFFF,
  parameter bit                     REFLECT    = 1'b1,
  parameter logic [POLY_WIDTH-1:0]  XOR_OUT    = 32'hFFFFFFFF,
  parameter int unsigned            DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [POLY_WIDTH-1:0] crc
);

  localparam int        PW       = int'(POLY_WIDTH);
  localparam int        DW       = int'(DATA_WIDTH);
  localparam crc_word_t POLY_EXT = crc_word_t'(POLY);
  localparam crc_word_t INIT_EXT = crc_word_t'(INIT);
  localparam crc_word_t XOR_EXT  = crc_word_t'(XOR_OUT);

  // Whole word in one expression so no wide intermediate is left half-used.
  assign crc = POLY_WIDTH'(XOR_EXT ^
                 (REFLECT
                    ? reflect_bits(crc_word(reflect_bytes(data_word_t'(data), DW),
                                            DW, POLY_EXT, INIT_EXT, PW), PW)
                    : crc_word(data_word_t'(data), DW, POLY_EXT, INIT_EXT, PW)));

endmodule

// File: rtl/parallel_crc.sv
// Single-cycle parallel CRC: combinational core plus registered result
// and a one-cycle valid pulse. Each word is checksummed independently.
module parallel_crc
  import crc_pkg::*;
#(
  parameter int unsigned            POLY_WIDTH = 32,
  parameter logic [POLY_WIDTH-1:0]  POLY       = 32'h04C11DB7,
  parameter logic [POLY_WIDTH-1:0]  INIT       = 32'hFFFFFFFF,
  parameter bit                     REFLECT    = 1'b1,
  parameter logic [POLY_WIDTH-1:0]  XOR_OUT    = 32'hFFFFFFFF,
  parameter int unsigned            DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic [POLY_WIDTH-1:0] crc_o,
  output logic                  crc_valid_o
);

  logic [POLY_WIDTH-1:0] crc_next;

  // Reject parameter sets the datapath cannot honour.
  if (POLY_WIDTH < 3 || POLY_WIDTH > MAX_POLY_WIDTH) begin : g_bad_poly_width
    $error("parallel_crc: POLY_WIDTH must be within 3..64");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
    $error("parallel_crc: DATA_WIDTH must be within 1..512");
  end
  if (REFLECT && (DATA_WIDTH % 8 != 0)) begin : g_bad_reflect_width
    $error("parallel_crc: DATA_WIDTH must be a multiple of 8 when REFLECT=1");
  end

  crc_comb_core #(
    .POLY_WIDTH (POLY_WIDTH),
    .POLY       (POLY),
    .INIT       (INIT),
    .REFLECT    (REFLECT),
    .XOR_OUT    (XOR_OUT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .data (data_i),
    .crc  (crc_next)
  );

  // Capture the result only for valid words so idle data never reaches crc_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
    end else begin
      crc_valid_o <= data_valid_i;
      if (data_valid_i) begin
        crc_o <= crc_next;
      end
    end
  end

endmodule

// File: tb/tb_parallel_crc.sv
// Bench for parallel_crc: five configurations side by side, a vector
// table fed through a per-instance expected-value queue, and hand-written
// sequences for hold, back-to-back, pulse width and reset priority.
module tb_parallel_crc;

  localparam int NCFG = 5;

  typedef struct {
    int          cfg;
    logic [71:0] data;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [4:0]  valid_vec;
  logic [7:0]  data_a;
  logic [71:0] data_b;
  logic [71:0] data_c;
  logic [71:0] data_d;
  logic [47:0] data_e;
  logic [7:0]  crc_a;
  logic [31:0] crc_b;
  logic [31:0] crc_c;
  logic [15:0] crc_d;
  logic [31:0] crc_e;
  logic [4:0]  valid_out;
  logic [31:0] crc_all [NCFG];

  int          checks;
  int          failures;
  int          valid_count [NCFG];
  logic [31:0] exp_q [NCFG][$];
  logic [31:0] mon_exp;
  string       cfg_name [NCFG];

  vec_t        vecs[$];

  // CRC-8 (poly 07, init 0, no reflection, no final XOR)
  parallel_crc #(
    .POLY_WIDTH(8), .POLY(8'h07), .INIT(8'h00), .REFLECT(1'b0),
    .XOR_OUT(8'h00), .DATA_WIDTH(8)
  ) u_crc8 (
    .clk(clk), .rst(rst), .data_i(data_a), .data_valid_i(valid_vec[0]),
    .crc_o(crc_a), .crc_valid_o(valid_out[0])
  );

  // CRC-32 default reflected configuration over nine bytes
  parallel_crc #(
    .DATA_WIDTH(72)
  ) u_crc32 (
    .clk(clk), .rst(rst), .data_i(data_b), .data_valid_i(valid_vec[1]),
    .crc_o(crc_b), .crc_valid_o(valid_out[1])
  );

  // CRC-32/MPEG-2
  parallel_crc #(
    .POLY_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFLECT(1'b0),
    .XOR_OUT(32'h00000000), .DATA_WIDTH(72)
  ) u_mpeg2 (
    .clk(clk), .rst(rst), .data_i(data_c), .data_valid_i(valid_vec[2]),
    .crc_o(crc_c), .crc_valid_o(valid_out[2])
  );

  // CRC-16/CCITT-FALSE
  parallel_crc #(
    .POLY_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .REFLECT(1'b0),
    .XOR_OUT(16'h0000), .DATA_WIDTH(72)
  ) u_ccitt (
    .clk(clk), .rst(rst), .data_i(data_d), .data_valid_i(valid_vec[3]),
    .crc_o(crc_d), .crc_valid_o(valid_out[3])
  );

  // 32-bit CRC with poly AF over 48-bit words
  parallel_crc #(
    .POLY_WIDTH(32), .POLY(32'h000000AF), .INIT(32'h00000000), .REFLECT(1'b0),
    .XOR_OUT(32'h00000000), .DATA_WIDTH(48)
  ) u_polyaf (
    .clk(clk), .rst(rst), .data_i(data_e), .data_valid_i(valid_vec[4]),
    .crc_o(crc_e), .crc_valid_o(valid_out[4])
  );

  assign crc_all[0] = {24'h0, crc_a};
  assign crc_all[1] = crc_b;
  assign crc_all[2] = crc_c;
  assign crc_all[3] = {16'h0, crc_d};
  assign crc_all[4] = crc_e;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upper bound on total run time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: init-0, unreflected CRC equals message * x^n mod G(x).
  function automatic logic [7:0] div_crc8(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [31:0] div_crc_af(input logic [47:0] d);
    logic [79:0] r;
    r = {d, 32'h0};
    for (int i = 79; i >= 32; i--) begin
      if (r[i]) r[i -: 33] = r[i -: 33] ^ 33'h1_0000_00AF;
    end
    return r[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one word into one instance for one cycle and record its expected CRC.
  task automatic applyStimulus(input int cfg, input logic [71:0] d, input logic [31:0] e);
    case (cfg)
      0:       data_a = d[7:0];
      1:       data_b = d;
      2:       data_c = d;
      3:       data_d = d;
      default: data_e = d[47:0];
    endcase
    valid_vec[cfg] = 1'b1;
    exp_q[cfg].push_back(e);
    @(posedge clk);
    #1;
    valid_vec = '0;
  endtask

  // Scoreboard: every valid pulse pops and checks the oldest expected result.
  always @(negedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      if (valid_out[k] === 1'b1) begin
        valid_count[k]++;
        if (exp_q[k].size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s unexpected valid: got crc %h required no output",
                   cfg_name[k], crc_all[k]);
        end else begin
          mon_exp = exp_q[k].pop_front();
          checkOutput(cfg_name[k], crc_all[k], mon_exp);
        end
      end
    end
  end

  initial begin
    logic [63:0] rnd;
    int          vc0;

    checks    = 0;
    failures  = 0;
    cfg_name  = '{"crc8", "crc32", "mpeg2", "ccitt", "poly_af"};
    for (int k = 0; k < NCFG; k++) valid_count[k] = 0;
    rst       = 1'b1;
    valid_vec = '0;
    data_a    = '0;
    data_b    = '0;
    data_c    = '0;
    data_d    = '0;
    data_e    = '0;

    // Vector table
    vecs.push_back('{0, 72'h01, 32'h07});
    vecs.push_back('{0, 72'h00, 32'h00});
    vecs.push_back('{0, 72'h80, 32'h89});
    vecs.push_back('{0, 72'hFF, 32'hF3});
    vecs.push_back('{0, 72'h02, 32'h0E});
    vecs.push_back('{1, 72'h313233343536373839, 32'hCBF43926});
    vecs.push_back('{2, 72'h313233343536373839, 32'h0376E6E7});
    vecs.push_back('{3, 72'h313233343536373839, 32'h000029B1});
    vecs.push_back('{4, 72'hAB5766123DDA, {div_crc_af(48'hAB5766123DDA)}});
    for (int n = 0; n < 4; n++) begin
      rnd = {32'h0, $urandom};
      vecs.push_back('{0, {64'h0, rnd[7:0]}, {24'h0, div_crc8(rnd[7:0])}});
    end
    for (int n = 0; n < 3; n++) begin
      rnd = {$urandom, $urandom};
      vecs.push_back('{4, {24'h0, rnd[47:0]}, div_crc_af(rnd[47:0])});
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      checkOutput({cfg_name[k], " reset crc"}, crc_all[k], 32'h0);
      checkOutput({cfg_name[k], " reset valid"}, {31'h0, valid_out[k]}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven vectors, one word per cycle
    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].cfg, vecs[v].data, vecs[v].exp);
    end
    repeat (3) @(posedge clk);
    #1;

    // Single word: one-cycle pulse, then the value holds with garbage data
    applyStimulus(0, 72'h80, 32'h89);
    data_a = 8'hxx;
    @(negedge clk);
    checkOutput("crc8 pulse high", {31'h0, valid_out[0]}, 32'h1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("crc8 pulse low", {31'h0, valid_out[0]}, 32'h0);
      checkOutput("crc8 hold", {24'h0, crc_a}, 32'h89);
    end
    @(posedge clk);
    #1;

    // Back-to-back words give back-to-back independent results
    vc0 = valid_count[0];
    applyStimulus(0, 72'h01, 32'h07);
    applyStimulus(0, 72'h00, 32'h00);
    @(negedge clk);
    checkOutput("b2b second valid", {31'h0, valid_out[0]}, 32'h1);
    checkOutput("b2b second crc", {24'h0, crc_a}, 32'h00);
    @(negedge clk);
    checkOutput("b2b valid cycles", valid_count[0] - vc0, 32'd2);
    checkOutput("b2b idle valid", {31'h0, valid_out[0]}, 32'h0);
    checkOutput("b2b idle hold", {24'h0, crc_a}, 32'h00);
    @(posedge clk);
    #1;

    // Reset coincident with valid: reset wins, nothing is produced
    applyStimulus(4, 72'hAB5766123DDA, div_crc_af(48'hAB5766123DDA));
    @(negedge clk);
    data_e         = 48'h123456789ABC;
    valid_vec[4]   = 1'b1;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    valid_vec = '0;
    rst       = 1'b0;
    @(negedge clk);
    checkOutput("reset prio crc", crc_e, 32'h0);
    checkOutput("reset prio valid", {31'h0, valid_out[4]}, 32'h0);

    // Recovery after reset
    applyStimulus(4, 72'h123456789ABC, div_crc_af(48'h123456789ABC));
    repeat (3) @(negedge clk);

    // Every queued expectation must have been consumed
    for (int k = 0; k < NCFG; k++) begin
      checkOutput({cfg_name[k], " drained"}, exp_q[k].size(), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
